pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller producing segment hold (stall) and
// clear (refresh) enables for a 5-stage pipeline.
// Priority: exception flush > data wait > divide hold > load-use > fetch wait
// > post-flush fetch discard.
// Optional feature macro: PIPE_CTRL_DIV_STALL_EN enables the multi-cycle
// divide hold FSM. Without it ex_div is ignored and div_busy is tied low.
module pipe_ctrl #(
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       id_rs_ren,
    input  logic       id_rt_ren,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_load,
    input  logic       ex_regwen,
    input  logic [4:0] ex_wreg,
    input  logic       ex_div,
    input  logic       inst_busy,
    input  logic       data_busy,
    input  logic       exc_flush,
    output logic [3:0] stall,
    output logic [3:0] refresh,
    output logic       div_busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DIV_BUSY   = 2'd1,
        DIV_DONE   = 2'd2,
        FLUSH_WAIT = 2'd3
    } state_t;

    state_t state;
    logic   div_hold_c;
    logic   load_use_c;

`ifdef PIPE_CTRL_DIV_STALL_EN
    localparam int unsigned CNT_W = 6;

    logic [CNT_W-1:0] cnt;

    // Divide hold covers the sampling cycle in IDLE plus every DIV_BUSY cycle
    assign div_hold_c = ((state == IDLE) && ex_div && !exc_flush) || (state == DIV_BUSY);
    assign div_busy   = (state == DIV_BUSY);

    // State and divide counter; flush aborts any divide in progress
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (exc_flush) begin
            state <= inst_busy ? FLUSH_WAIT : IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_div) begin
                        state <= DIV_BUSY;
                        cnt   <= CNT_W'(DIV_CYCLES - 2);
                    end
                end
                DIV_BUSY: begin
                    if (cnt == '0) begin
                        state <= DIV_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV_DONE: begin
                    state <= IDLE;
                end
                FLUSH_WAIT: begin
                    if (!inst_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    logic [6:0] unused_div_cfg;

    // Divide support compiled out: only IDLE and FLUSH_WAIT are reachable
    assign unused_div_cfg = {ex_div, 6'(DIV_CYCLES - 1)};
    assign div_hold_c     = 1'b0;
    assign div_busy       = 1'b0;

    // State register tracking only the post-flush fetch discard window
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (exc_flush) begin
            state <= inst_busy ? FLUSH_WAIT : IDLE;
        end else if ((state == FLUSH_WAIT) && !inst_busy) begin
            state <= IDLE;
        end else if (state != FLUSH_WAIT) begin
            state <= IDLE;
        end
    end
`endif

    // Load-use hazard: ID reads the register an in-flight load will write
    assign load_use_c = ex_load && ex_regwen && (ex_wreg != 5'd0) &&
                        ((id_rs_ren && (id_rs == ex_wreg)) ||
                         (id_rt_ren && (id_rt == ex_wreg)));

    // Prioritised hold/clear enables, forced low while in reset
    always_comb begin
        stall   = 4'b0000;
        refresh = 4'b0000;
        if (resetn) begin
            if (exc_flush) begin
                refresh = 4'b1111;
            end else if (data_busy) begin
                stall   = 4'b1111;
                refresh = 4'b1000;
            end else if (div_hold_c) begin
                stall   = 4'b0111;
                refresh = 4'b0100;
            end else if (load_use_c) begin
                stall   = 4'b0011;
                refresh = 4'b0010;
            end else if (inst_busy) begin
                stall   = 4'b0001;
                refresh = 4'b0001;
            end else if (state == FLUSH_WAIT) begin
                refresh = 4'b0001;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed bench for pipe_ctrl against a
// cycle-level behavioural model (remaining-hold counter plus flags).
module tb_pipe_ctrl;

    localparam int unsigned DIV_N = 33;
`ifdef PIPE_CTRL_DIV_STALL_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       id_rs_ren, id_rt_ren;
    logic [4:0] id_rs, id_rt;
    logic       ex_load, ex_regwen;
    logic [4:0] ex_wreg;
    logic       ex_div, inst_busy, data_busy, exc_flush;
    logic [3:0] stall, refresh;
    logic       div_busy;

    int checks = 0;
    int errors = 0;

    // Model state: divide hold cycles still owed, cycle-after-divide flag,
    // waiting-for-stale-fetch flag
    int unsigned div_left;
    bit          cool;
    bit          fw;
    logic [3:0]  exp_stall, exp_refresh;
    logic        exp_div_busy;

    pipe_ctrl #(.DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .id_rs_ren (id_rs_ren),
        .id_rt_ren (id_rt_ren),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .ex_load   (ex_load),
        .ex_regwen (ex_regwen),
        .ex_wreg   (ex_wreg),
        .ex_div    (ex_div),
        .inst_busy (inst_busy),
        .data_busy (data_busy),
        .exc_flush (exc_flush),
        .stall     (stall),
        .refresh   (refresh),
        .div_busy  (div_busy)
    );

    always #5 clk = ~clk;

    function automatic bit div_start();
        return DIV_EN && !fw && (div_left == 0) && !cool && ex_div && !exc_flush;
    endfunction

    task automatic model_eval();
        bit hold, lu;
        exp_stall    = 4'b0000;
        exp_refresh  = 4'b0000;
        exp_div_busy = 1'b0;
        if (resetn) begin
            hold = (div_left > 0) || div_start();
            exp_div_busy = (div_left > 0);
            lu = ex_load && ex_regwen && (ex_wreg != 0) &&
                 ((id_rs_ren && id_rs == ex_wreg) || (id_rt_ren && id_rt == ex_wreg));
            if (exc_flush)      begin exp_refresh = 4'b1111; end
            else if (data_busy) begin exp_stall = 4'b1111; exp_refresh = 4'b1000; end
            else if (hold)      begin exp_stall = 4'b0111; exp_refresh = 4'b0100; end
            else if (lu)        begin exp_stall = 4'b0011; exp_refresh = 4'b0010; end
            else if (inst_busy) begin exp_stall = 4'b0001; exp_refresh = 4'b0001; end
            else if (fw)        begin exp_refresh = 4'b0001; end
        end
    endtask

    task automatic model_commit();
        if (!resetn) begin
            div_left = 0; cool = 0; fw = 0;
        end else if (exc_flush) begin
            div_left = 0; cool = 0; fw = inst_busy;
        end else if (fw) begin
            fw = inst_busy;
        end else if (div_left > 0) begin
            div_left = div_left - 1;
            cool = (div_left == 0);
        end else if (div_start()) begin
            div_left = DIV_N - 1;
            cool = 0;
        end else begin
            cool = 0;
        end
    endtask

    task automatic clear_inputs();
        id_rs_ren = 0; id_rt_ren = 0; id_rs = '0; id_rt = '0;
        ex_load = 0; ex_regwen = 0; ex_wreg = '0; ex_div = 0;
        inst_busy = 0; data_busy = 0; exc_flush = 0;
    endtask

    task automatic drive_random(bit allow_reset, int unsigned flush_mod);
        resetn    = allow_reset ? ($urandom_range(99) != 0) : 1'b1;
        exc_flush = ($urandom_range(flush_mod - 1) == 0);
        data_busy = ($urandom_range(5) == 0);
        ex_div    = ($urandom_range(2) != 0);
        inst_busy = ($urandom_range(2) == 0);
        ex_load   = 1'($urandom_range(1));
        ex_regwen = 1'($urandom_range(1));
        ex_wreg   = 5'($urandom_range(3));
        id_rs_ren = 1'($urandom_range(1));
        id_rt_ren = 1'($urandom_range(1));
        id_rs     = 5'($urandom_range(3));
        id_rt     = 5'($urandom_range(3));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_random(1'b0, 4);
            resetn = 1'b0;
            #1;
            model_eval();
            checks++;
            if ({stall, refresh, div_busy} !== 9'b0) begin
                errors++;
                $display("FAIL reset cyc=%0d stall=%b refresh=%b div_busy=%b expected all zero",
                         i, stall, refresh, div_busy);
            end
            model_commit();
        end
        @(negedge clk);
        clear_inputs();
        resetn = 1'b1;
        #1;
        model_eval();
        checks++;
        if ({stall, refresh, div_busy} !== {exp_stall, exp_refresh, exp_div_busy}) begin
            errors++;
            $display("FAIL reset_release stall=%b refresh=%b div_busy=%b expected %b %b %b",
                     stall, refresh, div_busy, exp_stall, exp_refresh, exp_div_busy);
        end
        model_commit();
    endtask

    task automatic test_load_use();
        logic [4:0] cfg_wreg [4] = '{5'd5, 5'd0, 5'd5, 5'd5};
        logic       cfg_rs_en [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       cfg_rt_en [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] want_st [4] = '{4'b0011, 4'b0000, 4'b0011, 4'b0000};
        logic [3:0] want_rf [4] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            ex_load = 1; ex_regwen = 1; ex_wreg = cfg_wreg[i];
            id_rs_ren = cfg_rs_en[i]; id_rs = 5'd5;
            id_rt_ren = cfg_rt_en[i]; id_rt = 5'd5;
            #1;
            model_eval();
            checks++;
            if (stall !== want_st[i] || refresh !== want_rf[i]) begin
                errors++;
                $display("FAIL load_use_directed case=%0d stall=%b refresh=%b expected %b %b",
                         i, stall, refresh, want_st[i], want_rf[i]);
            end
            model_commit();
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive_random(1'b0, 4);
            exc_flush = 0; data_busy = 0; ex_div = 0; inst_busy = 0;
            #1;
            model_eval();
            checks++;
            if ({stall, refresh, div_busy} !== {exp_stall, exp_refresh, exp_div_busy}) begin
                errors++;
                $display("FAIL load_use_random cyc=%0d stall=%b refresh=%b div_busy=%b expected %b %b %b",
                         i, stall, refresh, div_busy, exp_stall, exp_refresh, exp_div_busy);
            end
            model_commit();
        end
    endtask

    task automatic test_divide(bit with_data_wait);
        int n_hold = 0, n_busy = 0, last_stall = 0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            clear_inputs();
            ex_div = (c <= DIV_N + 1);
            data_busy = with_data_wait && (c == 10);
            #1;
            model_eval();
            checks++;
            if ({stall, refresh, div_busy} !== {exp_stall, exp_refresh, exp_div_busy}) begin
                errors++;
                $display("FAIL divide dw=%0d cyc=%0d stall=%b refresh=%b div_busy=%b expected %b %b %b",
                         with_data_wait, c, stall, refresh, div_busy, exp_stall, exp_refresh, exp_div_busy);
            end
            if (stall == 4'b0111) n_hold++;
            if (div_busy) n_busy++;
            if (stall != 4'b0000) last_stall = c;
            model_commit();
        end
        checks++;
        if (DIV_EN) begin
            if (last_stall != DIV_N || n_busy != DIV_N - 1 ||
                n_hold != (with_data_wait ? DIV_N - 1 : DIV_N)) begin
                errors++;
                $display("FAIL divide_span dw=%0d last=%0d busy=%0d hold=%0d expected %0d %0d %0d",
                         with_data_wait, last_stall, n_busy, n_hold, DIV_N, DIV_N - 1,
                         with_data_wait ? DIV_N - 1 : DIV_N);
            end
        end else begin
            if (n_hold != 0 || n_busy != 0 || last_stall != (with_data_wait ? 10 : 0)) begin
                errors++;
                $display("FAIL divide_disabled hold=%0d busy=%0d last=%0d expected 0 0 %0d",
                         n_hold, n_busy, last_stall, with_data_wait ? 10 : 0);
            end
        end
    endtask

    task automatic test_flush_wait();
        logic [3:0] want_rf [6] = '{4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            clear_inputs();
            exc_flush = (c == 0);
            inst_busy = (c <= 3);
            #1;
            model_eval();
            checks++;
            if (refresh !== want_rf[c] || stall !== exp_stall || div_busy !== exp_div_busy) begin
                errors++;
                $display("FAIL flush_wait cyc=%0d stall=%b refresh=%b div_busy=%b expected %b %b %b",
                         c, stall, refresh, div_busy, exp_stall, want_rf[c], exp_div_busy);
            end
            model_commit();
        end
    endtask

    task automatic test_reset_mid_div();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            clear_inputs();
            ex_div = 1;
            inst_busy = (c == 5);
            #1;
            model_eval();
            checks++;
            if ({stall, refresh, div_busy} !== {exp_stall, exp_refresh, exp_div_busy}) begin
                errors++;
                $display("FAIL mid_div cyc=%0d stall=%b refresh=%b div_busy=%b expected %b %b %b",
                         c, stall, refresh, div_busy, exp_stall, exp_refresh, exp_div_busy);
            end
            if (c < 5) model_commit();
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({stall, refresh, div_busy} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset stall=%b refresh=%b div_busy=%b expected all zero",
                     stall, refresh, div_busy);
        end
        model_commit();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clear_inputs();
            resetn = 1'b1;
            ex_div = (c == 3);
            #1;
            model_eval();
            checks++;
            if ({stall, refresh, div_busy} !== {exp_stall, exp_refresh, exp_div_busy}) begin
                errors++;
                $display("FAIL post_reset cyc=%0d stall=%b refresh=%b div_busy=%b expected %b %b %b",
                         c, stall, refresh, div_busy, exp_stall, exp_refresh, exp_div_busy);
            end
            model_commit();
        end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        model_commit();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_random(int unsigned n, int unsigned flush_mod);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_random(1'b1, flush_mod);
            #1;
            model_eval();
            checks++;
            if ({stall, refresh, div_busy} !== {exp_stall, exp_refresh, exp_div_busy}) begin
                errors++;
                $display("FAIL random fm=%0d cyc=%0d stall=%b refresh=%b div_busy=%b expected %b %b %b",
                         flush_mod, i, stall, refresh, div_busy, exp_stall, exp_refresh, exp_div_busy);
            end
            model_commit();
        end
    endtask

    initial begin
        div_left = 0; cool = 0; fw = 0;
        clear_inputs();
        resetn = 1'b0;
        test_reset();
        test_load_use();
        test_divide(1'b0);
        test_divide(1'b1);
        test_flush_wait();
        test_reset_mid_div();
        test_random(2000, 200);
        test_random(2000, 15);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
